// File: rtl/devil_snoop_resp_arbiter.sv
`default_nettype none
// devil_snoop_resp_arbiter - shares the ACE snoop-response CR/CD path between the normal responder and the devil injector.
// Rev 1.0
module devil_snoop_resp_arbiter #(
    parameter int C_ACE_DATA_WIDTH = 128,
    parameter int C_LINE_BEATS     = 4,
    parameter int C_CNT_WIDTH      = 16
) (
    input  logic                        ace_aclk,
    input  logic                        ace_aresetn,
    input  logic                        i_cfg_devil_prio,
    input  logic                        i_cfg_delay_en,
    input  logic [31:0]                 i_cfg_delay,
    input  logic                        i_nrm_req_valid,
    input  logic [4:0]                  i_nrm_crresp,
    output logic                        o_nrm_req_ready,
    input  logic                        i_nrm_cdvalid,
    input  logic [C_ACE_DATA_WIDTH-1:0] i_nrm_cddata,
    input  logic                        i_nrm_cdlast,
    output logic                        o_nrm_cdready,
    input  logic                        i_dev_req_valid,
    input  logic [4:0]                  i_dev_crresp,
    output logic                        o_dev_req_ready,
    input  logic                        i_dev_cdvalid,
    input  logic [C_ACE_DATA_WIDTH-1:0] i_dev_cddata,
    input  logic                        i_dev_cdlast,
    output logic                        o_dev_cdready,
    output logic                        o_crvalid,
    output logic [4:0]                  o_crresp,
    input  logic                        i_crready,
    output logic                        o_cdvalid,
    output logic [C_ACE_DATA_WIDTH-1:0] o_cddata,
    output logic                        o_cdlast,
    input  logic                        i_cdready,
    output logic [1:0]                  o_grant,
    output logic [2:0]                  o_state,
    output logic [C_CNT_WIDTH-1:0]      o_fwd_count,
    output logic                        o_err
);

    localparam int                BEAT_W    = $clog2(C_LINE_BEATS + 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(C_LINE_BEATS);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_DELAY = 3'd1,
        S_CR    = 3'd2,
        S_CD    = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                  state;
    logic [1:0]              grant;
    logic                    last_dev;
    logic [31:0]             delay_cnt;
    logic [BEAT_W-1:0]       beat_cnt;
    logic [4:0]              crresp_q;
    logic                    crvalid_q;
    logic [C_CNT_WIDTH-1:0]  fwd_count;
    logic                    err_q;

    logic                    any_req;
    logic                    pick_dev;
    logic                    accept;
    logic                    in_cd;
    logic                    sel_dev;
    logic                    src_valid;
    logic                    src_last;
    logic [C_ACE_DATA_WIDTH-1:0] src_data;
    logic                    cd_hs;
    logic [BEAT_W-1:0]       beat_num;

    // DEV wins on its own, under priority mode, or when NRM was granted last.
    assign any_req  = i_nrm_req_valid | i_dev_req_valid;
    assign pick_dev = i_dev_req_valid & (~i_nrm_req_valid | i_cfg_devil_prio | ~last_dev);
    // Ready is gated by reset so no accept can complete while reset is held.
    assign accept   = ace_aresetn & (state == S_IDLE) & any_req;

    assign o_dev_req_ready = accept & pick_dev;
    assign o_nrm_req_ready = accept & ~pick_dev;

    assign in_cd     = (state == S_CD);
    assign sel_dev   = grant[1];
    assign src_valid = sel_dev ? i_dev_cdvalid : i_nrm_cdvalid;
    assign src_last  = sel_dev ? i_dev_cdlast  : i_nrm_cdlast;
    assign src_data  = sel_dev ? i_dev_cddata  : i_nrm_cddata;
    assign cd_hs     = in_cd & src_valid & i_cdready;
    assign beat_num  = beat_cnt + 1'b1;

    assign o_cdvalid     = in_cd & src_valid;
    assign o_cdlast      = in_cd & src_last;
    assign o_cddata      = in_cd ? src_data : '0;
    assign o_nrm_cdready = in_cd & grant[0] & i_cdready;
    assign o_dev_cdready = in_cd & grant[1] & i_cdready;

    assign o_crvalid   = crvalid_q;
    assign o_crresp    = crresp_q;
    assign o_grant     = grant;
    assign o_state     = state;
    assign o_fwd_count = fwd_count;
    assign o_err       = err_q;

    always_ff @(posedge ace_aclk or negedge ace_aresetn) begin
        if (!ace_aresetn) begin
            state     <= S_IDLE;
            grant     <= 2'b00;
            last_dev  <= 1'b0;
            delay_cnt <= 32'd0;
            beat_cnt  <= '0;
            crresp_q  <= 5'd0;
            crvalid_q <= 1'b0;
            fwd_count <= '0;
            err_q     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        grant    <= pick_dev ? 2'b10 : 2'b01;
                        crresp_q <= pick_dev ? i_dev_crresp : i_nrm_crresp;
                        if (pick_dev && i_cfg_delay_en && (i_cfg_delay != 32'd0)) begin
                            delay_cnt <= i_cfg_delay;
                            state     <= S_DELAY;
                        end else begin
                            crvalid_q <= 1'b1;
                            state     <= S_CR;
                        end
                    end
                end
                S_DELAY: begin
                    // The loaded value is used as-is; config inputs are not looked at here.
                    if (delay_cnt == 32'd1) begin
                        delay_cnt <= 32'd0;
                        crvalid_q <= 1'b1;
                        state     <= S_CR;
                    end else begin
                        delay_cnt <= delay_cnt - 32'd1;
                    end
                end
                S_CR: begin
                    if (i_crready) begin
                        crvalid_q <= 1'b0;
                        beat_cnt  <= '0;
                        state     <= crresp_q[0] ? S_CD : S_DONE;
                    end
                end
                S_CD: begin
                    if (cd_hs) begin
                        beat_cnt <= beat_num;
                        // A line ends on last or on the final beat, whichever comes first;
                        // any disagreement between the two is flagged.
                        if (src_last || (beat_num == LAST_BEAT)) begin
                            state <= S_DONE;
                            if (src_last != (beat_num == LAST_BEAT)) begin
                                err_q <= 1'b1;
                            end
                        end
                    end
                end
                S_DONE: begin
                    fwd_count <= fwd_count + 1'b1;
                    last_dev  <= grant[1];
                    grant     <= 2'b00;
                    state     <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_devil_snoop_resp_arbiter.sv
`default_nettype none
// tb_devil_snoop_resp_arbiter - directed plus randomized transactions checked against a transaction-level model.
// Rev 1.0
module tb_devil_snoop_resp_arbiter;

    localparam int DW = 128;
    localparam int LB = 4;
    localparam int CW = 4;

    logic          ace_aclk = 1'b0;
    logic          ace_aresetn;
    logic          i_cfg_devil_prio, i_cfg_delay_en;
    logic [31:0]   i_cfg_delay;
    logic          i_nrm_req_valid, o_nrm_req_ready, i_nrm_cdvalid, i_nrm_cdlast, o_nrm_cdready;
    logic [4:0]    i_nrm_crresp;
    logic [DW-1:0] i_nrm_cddata;
    logic          i_dev_req_valid, o_dev_req_ready, i_dev_cdvalid, i_dev_cdlast, o_dev_cdready;
    logic [4:0]    i_dev_crresp;
    logic [DW-1:0] i_dev_cddata;
    logic          o_crvalid, i_crready, o_cdvalid, o_cdlast, i_cdready, o_err;
    logic [4:0]    o_crresp;
    logic [DW-1:0] o_cddata;
    logic [1:0]    o_grant;
    logic [2:0]    o_state;
    logic [CW-1:0] o_fwd_count;

    devil_snoop_resp_arbiter #(
        .C_ACE_DATA_WIDTH(DW),
        .C_LINE_BEATS    (LB),
        .C_CNT_WIDTH     (CW)
    ) dut (
        .ace_aclk        (ace_aclk),
        .ace_aresetn     (ace_aresetn),
        .i_cfg_devil_prio(i_cfg_devil_prio),
        .i_cfg_delay_en  (i_cfg_delay_en),
        .i_cfg_delay     (i_cfg_delay),
        .i_nrm_req_valid (i_nrm_req_valid),
        .i_nrm_crresp    (i_nrm_crresp),
        .o_nrm_req_ready (o_nrm_req_ready),
        .i_nrm_cdvalid   (i_nrm_cdvalid),
        .i_nrm_cddata    (i_nrm_cddata),
        .i_nrm_cdlast    (i_nrm_cdlast),
        .o_nrm_cdready   (o_nrm_cdready),
        .i_dev_req_valid (i_dev_req_valid),
        .i_dev_crresp    (i_dev_crresp),
        .o_dev_req_ready (o_dev_req_ready),
        .i_dev_cdvalid   (i_dev_cdvalid),
        .i_dev_cddata    (i_dev_cddata),
        .i_dev_cdlast    (i_dev_cdlast),
        .o_dev_cdready   (o_dev_cdready),
        .o_crvalid       (o_crvalid),
        .o_crresp        (o_crresp),
        .i_crready       (i_crready),
        .o_cdvalid       (o_cdvalid),
        .o_cddata        (o_cddata),
        .o_cdlast        (o_cdlast),
        .i_cdready       (i_cdready),
        .o_grant         (o_grant),
        .o_state         (o_state),
        .o_fwd_count     (o_fwd_count),
        .o_err           (o_err)
    );

    always #5 ace_aclk = ~ace_aclk;

    int tests = 0;
    int fails = 0;

    // Transaction-level model: who was served last, how many completed, sticky error.
    bit            m_last_dev;
    logic [CW-1:0] m_count;
    bit            m_err;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge ace_aclk);
        #1;
    endtask

    task automatic idle_inputs;
        i_nrm_req_valid = 1'b0; i_dev_req_valid = 1'b0;
        i_nrm_cdvalid   = 1'b0; i_dev_cdvalid   = 1'b0;
        i_nrm_cdlast    = 1'b0; i_dev_cdlast    = 1'b0;
        i_crready       = 1'b0; i_cdready       = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check(tag, {o_nrm_req_ready, o_dev_req_ready, o_nrm_cdready, o_dev_cdready, o_crvalid,
                    o_crresp, o_cdvalid, o_cdlast, o_grant, o_state, o_fwd_count, o_err}, 128'd0);
        check({tag, "_data"}, o_cddata, 128'd0);
    endtask

    // One complete transaction. last_at: beat carrying last (>LB means no last within the line).
    task automatic do_txn(input bit nv, input bit dv, input bit prio, input bit den, input int dly,
                          input logic [4:0] crn, input logic [4:0] crd, input int last_at,
                          input int crwait, input bit rst_mid);
        bit            win_dev, eerr, sv;
        logic [4:0]    ecr;
        int            elat, lat, eacc, idx, guard;
        logic [DW-1:0] beats [8];

        win_dev = (nv && dv) ? (prio || !m_last_dev) : dv;
        ecr     = win_dev ? crd : crn;
        elat    = (win_dev && den && dly != 0) ? 1 + dly : 1;
        if (last_at < LB)       begin eacc = last_at; eerr = 1'b1; end
        else if (last_at == LB) begin eacc = LB;      eerr = 1'b0; end
        else                    begin eacc = LB;      eerr = 1'b1; end
        for (int i = 0; i < 8; i++) beats[i] = {$urandom(), $urandom(), $urandom(), $urandom()};

        step();
        i_nrm_req_valid = nv; i_dev_req_valid = dv;
        i_nrm_crresp = crn;   i_dev_crresp = crd;
        i_cfg_devil_prio = prio; i_cfg_delay_en = den; i_cfg_delay = dly;
        @(negedge ace_aclk);
        check("accept_state", o_state, 0);
        check("nrm_req_ready", o_nrm_req_ready, !win_dev);
        check("dev_req_ready", o_dev_req_ready, win_dev);

        // Scramble inputs the DUT must already have captured.
        step();
        i_nrm_req_valid = 1'b0; i_dev_req_valid = 1'b0;
        i_nrm_crresp = 5'($urandom()); i_dev_crresp = 5'($urandom());
        i_cfg_delay_en = 1'($urandom()); i_cfg_delay = $urandom_range(0, 9);
        lat = 1;
        @(negedge ace_aclk);
        while (!o_crvalid && lat < 100) begin
            check("wait_quiet", {o_cdvalid, o_nrm_req_ready, o_dev_req_ready}, 0);
            step();
            @(negedge ace_aclk);
            lat++;
        end
        check("cr_latency", lat, elat);
        check("grant", o_grant, win_dev ? 2'b10 : 2'b01);
        check("crresp", o_crresp, ecr);
        for (int w = 0; w < crwait; w++) begin
            step();
            @(negedge ace_aclk);
            check("cr_hold", {o_crvalid, o_crresp, o_state}, {1'b1, ecr, 3'd2});
        end
        i_crready = 1'b1;
        step();
        i_crready = 1'b0;

        if (ecr[0]) begin
            idx = 0; guard = 0;
            while (idx < eacc && guard < 200) begin
                if (win_dev) begin
                    i_dev_cdvalid = ($urandom() % 4) != 0; i_dev_cddata = beats[idx];
                    i_dev_cdlast  = (idx + 1 == last_at);
                    i_nrm_cdvalid = 1'($urandom()); i_nrm_cddata = ~beats[idx]; i_nrm_cdlast = 1'($urandom());
                end else begin
                    i_nrm_cdvalid = ($urandom() % 4) != 0; i_nrm_cddata = beats[idx];
                    i_nrm_cdlast  = (idx + 1 == last_at);
                    i_dev_cdvalid = 1'($urandom()); i_dev_cddata = ~beats[idx]; i_dev_cdlast = 1'($urandom());
                end
                i_cdready = ($urandom() % 3) != 0;
                @(negedge ace_aclk);
                if (rst_mid && idx == 1) begin
                    ace_aresetn = 1'b0;
                    #1;
                    check_reset_outputs("rst_mid");
                    m_count = '0; m_err = 1'b0; m_last_dev = 1'b0;
                    idle_inputs();
                    step();
                    step();
                    @(negedge ace_aclk);
                    check_reset_outputs("rst_hold");
                    ace_aresetn = 1'b1;
                    return;
                end
                sv = win_dev ? i_dev_cdvalid : i_nrm_cdvalid;
                check("cdvalid", o_cdvalid, sv);
                check("cdready_gnt", win_dev ? o_dev_cdready : o_nrm_cdready, i_cdready);
                check("cdready_other", win_dev ? o_nrm_cdready : o_dev_cdready, 0);
                if (sv) begin
                    check("cddata", o_cddata, beats[idx]);
                    check("cdlast", o_cdlast, idx + 1 == last_at);
                    if (i_cdready) idx++;
                end
                step();
                guard++;
            end
            check("beats_taken", idx, eacc);
            idle_inputs();
        end

        @(negedge ace_aclk);
        check("done_state", o_state, 4);
        check("done_quiet", {o_cdvalid, o_crvalid}, 0);
        m_count    = m_count + 1'b1;
        m_last_dev = win_dev;
        if (ecr[0]) m_err = m_err | eerr;
        step();
        @(negedge ace_aclk);
        check("idle_state", o_state, 0);
        check("grant_clear", o_grant, 0);
        check("fwd_count", o_fwd_count, m_count);
        check("err", o_err, m_err);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int r, la;
        idle_inputs();
        i_cfg_devil_prio = 1'b0; i_cfg_delay_en = 1'b0; i_cfg_delay = 32'd0;
        i_nrm_crresp = 5'd0; i_dev_crresp = 5'd0; i_nrm_cddata = '0; i_dev_cddata = '0;
        m_last_dev = 1'b0; m_count = '0; m_err = 1'b0;
        ace_aresetn = 1'b0;
        #23;
        check_reset_outputs("reset");
        @(negedge ace_aclk);
        ace_aresetn = 1'b1;

        // NRM only, no data.
        do_txn(1, 0, 0, 0, 0, 5'b00000, 5'b00000, LB, 0, 0);
        // DEV with delay 3 and a full line.
        do_txn(0, 1, 0, 1, 3, 5'b00000, 5'b00001, LB, 0, 0);
        // Contention, round-robin then DEV priority.
        for (int i = 0; i < 6; i++) do_txn(1, 1, 0, 0, 0, 5'($urandom()), 5'($urandom()), LB, 0, 0);
        for (int i = 0; i < 6; i++) do_txn(1, 1, 1, 0, 0, 5'($urandom()), 5'($urandom()), LB, 0, 0);
        // Early last.
        do_txn(0, 1, 0, 0, 0, 5'b00000, 5'b00001, 2, 0, 0);
        // Reset mid-line, then a clean NRM transaction.
        do_txn(1, 0, 0, 0, 0, 5'b00001, 5'b00000, LB, 0, 1);
        do_txn(1, 0, 0, 0, 0, 5'b00000, 5'b00000, LB, 0, 0);
        // Long CRREADY backpressure.
        do_txn(1, 0, 0, 0, 0, 5'b10100, 5'b00000, LB, 10, 0);

        for (int t = 0; t < 40; t++) begin
            r = $urandom_range(1, 3);
            case ($urandom() % 6)
                0:       la = 2;
                1:       la = 6;
                default: la = LB;
            endcase
            do_txn(r[0], r[1], 1'($urandom()), 1'($urandom()), $urandom_range(0, 5),
                   5'($urandom()), 5'($urandom()), la, $urandom_range(0, 3), 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
